// File: rtl/wshb_pkg.sv
// -----------------------------------------------------------------------------
// wshb_pkg
// Shared Wishbone definitions for the arbiter and its neighbours.
//   CTI_*       : cycle type identifier codes (classic, incrementing, end-of-burst)
//   BTE_LINEAR  : linear burst type extension code
//   arb_state_t : arbiter FSM state (IDLE waiting for requests, BUSY owned by a master)
// -----------------------------------------------------------------------------
package wshb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin one-hot pick: returns the first set bit of req_i
// found scanning upward from index ptr_i, wrapping past N-1 back to 0.
//   req_i [N-1:0]     request vector
//   ptr_i [PTR_W-1:0] index that has highest priority this round
//   gnt_o [N-1:0]     one-hot grant (all zero when req_i is zero)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic [2*N-1:0] req2_s;
    logic [2*N-1:0] keep_s;
    logic [2*N-1:0] masked_s;
    logic [2*N-1:0] first_s;

    // Double-width mask trick: the upper copy of req holds the wrapped-around
    // indices, so the lowest set bit at or above ptr is the round-robin winner.
    always_comb begin
        req2_s   = {req_i, req_i};
        keep_s   = ~(((2*N)'(1) << ptr_i) - (2*N)'(1));
        masked_s = req2_s & keep_s;
        first_s  = masked_s & (~masked_s + (2*N)'(1));
        gnt_o    = first_s[N-1:0] | first_s[2*N-1:N];
    end

endmodule

// File: rtl/wshb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// wshb_arbiter_rr
// N-master to 1-slave Wishbone arbiter with round-robin fairness. A master keeps
// the grant for its whole cyc; an optional watchdog raises err when the slave
// leaves stb unanswered for TMO_CYC cycles.
//   clk, rst_n                 clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we [N]       per-master control
//   m_adr/m_sel/m_dat_ms       per-master address, byte selects, write data (packed)
//   m_cti/m_bte                per-master cycle type / burst type (packed)
//   m_ack/m_err [N]            responses, only to the granted master
//   m_dat_sm                   slave read data, broadcast
//   s_*                        slave side of the selected master
//   grant [N]                  registered one-hot grant
// -----------------------------------------------------------------------------
module wshb_arbiter_rr
    import wshb_pkg::*;
#(
    parameter int N_MST   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MST-1:0]            m_cyc,
    input  logic [N_MST-1:0]            m_stb,
    input  logic [N_MST-1:0]            m_we,
    input  logic [N_MST*ADDR_W-1:0]     m_adr,
    input  logic [N_MST*DATA_W/8-1:0]   m_sel,
    input  logic [N_MST*DATA_W-1:0]     m_dat_ms,
    input  logic [N_MST*3-1:0]          m_cti,
    input  logic [N_MST*2-1:0]          m_bte,
    output logic [N_MST-1:0]            m_ack,
    output logic [N_MST-1:0]            m_err,
    output logic [DATA_W-1:0]           m_dat_sm,
    output logic                        s_cyc,
    output logic                        s_stb,
    output logic                        s_we,
    output logic [ADDR_W-1:0]           s_adr,
    output logic [DATA_W/8-1:0]         s_sel,
    output logic [DATA_W-1:0]           s_dat_ms,
    output logic [2:0]                  s_cti,
    output logic [1:0]                  s_bte,
    input  logic                        s_ack,
    input  logic                        s_err,
    input  logic [DATA_W-1:0]           s_dat_sm,
    output logic [N_MST-1:0]            grant
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam bit TMO_EN = (TMO_CYC > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    arb_state_t         state_q,   state_d;
    logic [N_MST-1:0]   grant_q,   grant_d;
    logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [N_MST-1:0]   pick_s;
    logic [PTR_W-1:0]   g_idx_s;
    logic               owner_cyc_s;
    logic               pend_s;
    logic               tmo_hit_s;

    rr_pick #(
        .N     (N_MST),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (m_cyc),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_s)
    );

    // Owner index from the one-hot grant; OR-reduction works because at most one bit is set.
    always_comb begin
        g_idx_s = '0;
        for (int i = 0; i < N_MST; i++) begin
            g_idx_s = g_idx_s | (grant_q[i] ? PTR_W'(i) : PTR_W'(0));
        end
    end

    // AND-OR mux from the registered grant; with no grant every s_* output is zero.
    always_comb begin
        s_adr    = '0;
        s_sel    = '0;
        s_dat_ms = '0;
        s_cti    = 3'b000;
        s_bte    = 2'b00;
        for (int i = 0; i < N_MST; i++) begin
            s_adr    = s_adr    | (m_adr[i*ADDR_W +: ADDR_W]    & {ADDR_W{grant_q[i]}});
            s_sel    = s_sel    | (m_sel[i*SEL_W +: SEL_W]      & {SEL_W{grant_q[i]}});
            s_dat_ms = s_dat_ms | (m_dat_ms[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
            s_cti    = s_cti    | (m_cti[i*3 +: 3]              & {3{grant_q[i]}});
            s_bte    = s_bte    | (m_bte[i*2 +: 2]              & {2{grant_q[i]}});
        end
        s_cyc       = |(m_cyc & grant_q);
        s_stb       = |(m_stb & grant_q);
        s_we        = |(m_we  & grant_q);
        owner_cyc_s = s_cyc;
    end

    // Responses reach only the owner; read data is broadcast.
    always_comb begin
        m_ack    = {N_MST{s_ack}} & grant_q;
        m_err    = {N_MST{s_err | tmo_hit_s}} & grant_q;
        m_dat_sm = s_dat_sm;
        grant    = grant_q;
    end

    // Arbitration FSM next state: grant in IDLE, release in BUSY when the owner drops cyc.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    grant_d = pick_s;
                    state_d = BUSY;
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!owner_cyc_s) begin
                    grant_d  = '0;
                    state_d  = IDLE;
                    rr_ptr_d = (g_idx_s == PTR_W'(N_MST - 1)) ? PTR_W'(0) : (g_idx_s + PTR_W'(1));
                end else begin
                    grant_d = grant_q;
                    state_d = BUSY;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Watchdog: count unanswered stb cycles, fire once at the limit, then start over.
    always_comb begin
        pend_s    = s_stb & ~s_ack & ~s_err;
        tmo_hit_s = TMO_EN & pend_s & (tmo_cnt_q == TMO_LAST);
        if (!TMO_EN || !pend_s || tmo_hit_s) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == CNT_MAX) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    // State, grant, pointer and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
module tb_wshb_arbiter_rr;
    import wshb_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0]   m_adr = '0;
    logic [N*SW-1:0]   m_sel = '0;
    logic [N*DW-1:0]   m_dat_ms = '0;
    logic [N*3-1:0]    m_cti = '0;
    logic [N*2-1:0]    m_bte = '0;
    logic [N-1:0]      m_ack, m_err, grant;
    logic [DW-1:0]     m_dat_sm;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [SW-1:0]     s_sel;
    logic [DW-1:0]     s_dat_ms;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic              s_ack = 1'b0, s_err = 1'b0;
    logic [DW-1:0]     s_dat_sm = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: current owner (-1 = none), round-robin start, watchdog count
    int owner = -1;
    int ptr   = 0;
    int cnt   = 0;

    always #5 clk = ~clk;

    wshb_arbiter_rr #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
        .m_dat_ms(m_dat_ms), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_ms(s_dat_ms), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_dat_sm(s_dat_sm),
        .grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            m_adr[i*AW +: AW]    = $urandom;
            m_dat_ms[i*DW +: DW] = $urandom;
            m_sel[i*SW +: SW]    = 4'($urandom);
            m_cti[i*3 +: 3]      = 3'($urandom);
            m_bte[i*2 +: 2]      = 2'($urandom);
        end
        m_we     = 4'($urandom);
        s_dat_sm = $urandom;
    endtask

    task automatic set_req(input logic [N-1:0] cyc);
        m_cyc = cyc;
        m_stb = cyc;
        rand_payload();
    endtask

    function automatic logic model_stb();
        return (owner >= 0) ? m_stb[owner] : 1'b0;
    endfunction

    function automatic logic model_hit();
        return model_stb() && !s_ack && !s_err && (cnt == TMO - 1);
    endfunction

    // compare every DUT output with what the model says for the present inputs
    task automatic model_check();
        logic [N-1:0]  eg;
        logic          ecyc, estb, ewe;
        logic [AW-1:0] eadr;
        logic [SW-1:0] esel;
        logic [DW-1:0] edat;
        logic [2:0]    ecti;
        logic [1:0]    ebte;
        #2;
        if (owner >= 0) begin
            eg   = 4'(1 << owner);
            ecyc = m_cyc[owner];
            estb = m_stb[owner];
            ewe  = m_we[owner];
            eadr = m_adr[owner*AW +: AW];
            esel = m_sel[owner*SW +: SW];
            edat = m_dat_ms[owner*DW +: DW];
            ecti = m_cti[owner*3 +: 3];
            ebte = m_bte[owner*2 +: 2];
        end else begin
            eg = '0; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
            eadr = '0; esel = '0; edat = '0; ecti = '0; ebte = '0;
        end
        chk("grant",    64'(grant),    64'(eg));
        chk("s_cyc",    64'(s_cyc),    64'(ecyc));
        chk("s_stb",    64'(s_stb),    64'(estb));
        chk("s_we",     64'(s_we),     64'(ewe));
        chk("s_adr",    64'(s_adr),    64'(eadr));
        chk("s_sel",    64'(s_sel),    64'(esel));
        chk("s_dat_ms", 64'(s_dat_ms), 64'(edat));
        chk("s_cti",    64'(s_cti),    64'(ecti));
        chk("s_bte",    64'(s_bte),    64'(ebte));
        chk("m_ack",    64'(m_ack),    64'(s_ack ? eg : 4'b0000));
        chk("m_err",    64'(m_err),    64'((s_err || model_hit()) ? eg : 4'b0000));
        chk("m_dat_sm", 64'(m_dat_sm), 64'(s_dat_sm));
    endtask

    // advance model and DUT by one clock edge
    task automatic tick();
        int  no, np, nc;
        logic pend;
        no = owner; np = ptr; nc = cnt;
        if (!rst_n) begin
            no = -1; np = 0; nc = 0;
        end else begin
            if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (no < 0 && m_cyc[(ptr + k) % N]) no = (ptr + k) % N;
                end
            end else if (!m_cyc[owner]) begin
                no = -1;
                np = (owner + 1) % N;
            end
            pend = model_stb() && !s_ack && !s_err;
            nc = (!pend || model_hit()) ? 0 : cnt + 1;
        end
        @(posedge clk);
        #1;
        owner = no; ptr = np; cnt = nc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(4'b0000);
        s_ack = 1'b0;
        s_err = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int acnt[2];
        logic [N-1:0] seq[$];
        logic [N-1:0] seq_exp[6];
        logic [N-1:0] obs;

        // 1. reset with every master requesting
        @(posedge clk);
        #1;
        set_req(4'b1111);
        s_ack = 1'b1;
        model_check();
        chk("t1_scyc_rst", 64'(s_cyc), 64'(0));
        chk("t1_grant_rst", 64'(grant), 64'(0));
        tick();
        rst_n = 1'b1;
        model_check();
        chk("t1_grant_lat", 64'(grant), 64'(0));
        tick();
        model_check();
        chk("t1_grant_first", 64'(grant), 64'(4'b0001));

        // 2. two masters, each releases after 4 acks
        do_reset();
        s_ack = 1'b1;
        acnt[0] = 0; acnt[1] = 0;
        for (int c = 0; c < 24; c++) begin
            m_cyc = 4'b0000;
            for (int i = 0; i < 2; i++) begin
                m_cyc[i] = (acnt[i] != 4);
                if (acnt[i] == 4) acnt[i] = 0;
            end
            m_stb = m_cyc;
            rand_payload();
            model_check();
            if (seq.size() == 0 || seq[$] !== grant) seq.push_back(grant);
            for (int i = 0; i < 2; i++) if (m_ack[i] && m_cyc[i]) acnt[i]++;
            tick();
        end
        seq_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
        for (int k = 0; k < 6; k++) begin
            obs = (k < seq.size()) ? seq[k] : 4'hF;
            chk($sformatf("t2_seq%0d", k), 64'(obs), 64'(seq_exp[k]));
        end

        // 3. rr_ptr=2 with masters 1 and 3 requesting
        do_reset();
        s_ack = 1'b1;
        set_req(4'b0010); model_check(); tick();
        set_req(4'b0000); model_check(); tick();
        set_req(4'b1010); model_check(); tick();
        model_check();
        chk("t3_first", 64'(grant), 64'(4'b1000));
        set_req(4'b0010); model_check(); tick();
        model_check();
        chk("t3_gap", 64'(grant), 64'(0));
        tick();
        model_check();
        chk("t3_second", 64'(grant), 64'(4'b0010));

        // 4. 8-beat burst by master 0 while master 1 waits
        do_reset();
        s_ack = 1'b1;
        set_req(4'b0011); model_check(); tick();
        for (int b = 0; b < 8; b++) begin
            rand_payload();
            m_cti[2:0] = (b == 7) ? CTI_EOB : CTI_INCR;
            m_bte[1:0] = BTE_LINEAR;
            model_check();
            chk("t4_hold", 64'(grant), 64'(4'b0001));
            chk("t4_cti", 64'(s_cti), 64'((b == 7) ? 3'b111 : 3'b010));
            tick();
        end
        set_req(4'b0010); model_check(); tick();
        model_check();
        chk("t4_gap", 64'(grant), 64'(0));
        tick();
        model_check();
        chk("t4_next", 64'(grant), 64'(4'b0010));

        // 5. slave never acks: watchdog err on the 16th pending cycle
        do_reset();
        s_ack = 1'b0;
        set_req(4'b0011);
        m_stb = 4'b0001;
        model_check(); tick();
        for (int c = 0; c < 20; c++) begin
            model_check();
            chk($sformatf("t5_err%0d", c), 64'(m_err), 64'((c == 15) ? 4'b0001 : 4'b0000));
            tick();
        end

        // 6. async reset mid-burst, pointer back to 0
        do_reset();
        s_ack = 1'b1;
        set_req(4'b0001); model_check(); tick();
        set_req(4'b0000); model_check(); tick();
        set_req(4'b0010); model_check(); tick();
        model_check(); tick();
        model_check();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_scyc_async", 64'(s_cyc), 64'(0));
        chk("t6_grant_async", 64'(grant), 64'(0));
        owner = -1; ptr = 0; cnt = 0;
        tick();
        rst_n = 1'b1;
        set_req(4'b0011); model_check(); tick();
        model_check();
        chk("t6_ptr0", 64'(grant), 64'(4'b0001));

        // 7. random traffic against the model, with slow-slave stretches
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bit slow;
            slow = ((c % 200) < 90);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(slow ? 63 : 7, 0) == 0) m_cyc[i] = ~m_cyc[i];
            end
            m_stb = slow ? m_cyc : (m_cyc & 4'($urandom));
            rand_payload();
            s_ack = slow ? ($urandom_range(19, 0) == 0) : ($urandom_range(3, 0) == 0);
            s_err = ($urandom_range(31, 0) == 0);
            model_check();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
